// File: rtl/segre_pkg.sv
// Shared I-cache geometry, controller FSM states and tag type.
package segre_pkg;

  localparam int unsigned WORD_SIZE         = 32;
  localparam int unsigned ICACHE_BYTE_SIZE  = 4;
  localparam int unsigned ICACHE_INDEX_SIZE = 2;
  localparam int unsigned ICACHE_NUM_LANES  = 4;
  localparam int unsigned ICACHE_TAG_SIZE   = WORD_SIZE - ICACHE_INDEX_SIZE - ICACHE_BYTE_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    REPLAY
  } icache_state_t;

  typedef logic [ICACHE_TAG_SIZE-1:0] icache_tag_t;

endpackage

// File: rtl/segre_icache_ctrl_if.sv
// Fetch-side bus between the fetch stage (master) and the I-cache controller (slave).
interface segre_icache_ctrl_if #(
  parameter int unsigned WORD_SIZE = 32
);
  logic                 fetch_req;
  logic [WORD_SIZE-1:0] fetch_addr;
  logic                 fetch_ready;
  logic                 fetch_valid;
  logic                 invalidate;

  modport master (
    output fetch_req,
    output fetch_addr,
    output invalidate,
    input  fetch_ready,
    input  fetch_valid
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    input  invalidate,
    output fetch_ready,
    output fetch_valid
  );
endinterface

// File: rtl/segre_icache_tag.sv
// Tag + valid store: combinational lookup, synchronous write and clear-all.
module segre_icache_tag #(
  parameter int unsigned TAG_SIZE   = 26,
  parameter int unsigned INDEX_SIZE = 2,
  parameter int unsigned NUM_LANES  = 4
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic [INDEX_SIZE-1:0] rd_index_i,
  input  logic [TAG_SIZE-1:0]   rd_tag_i,
  output logic                  hit_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_SIZE-1:0] wr_index_i,
  input  logic [TAG_SIZE-1:0]   wr_tag_i,
  input  logic                  clear_i
);

  logic [NUM_LANES-1:0] valid_q, valid_d;
  logic [TAG_SIZE-1:0]  tag_q [NUM_LANES];
  logic [TAG_SIZE-1:0]  tag_d [NUM_LANES];

  assign hit_o = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (wr_en_i) begin
      valid_d[wr_index_i] = 1'b1;
      tag_d[wr_index_i]   = wr_tag_i;
    end
    if (clear_i) begin
      valid_d = '0;
    end
  end

  // Tags need no reset: a lane is only trusted once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q <= tag_d;
  end

endmodule

// File: rtl/segre_icache_ctrl.sv
// I-cache controller: hit/miss decision, line refill from the MMU and replay of the miss.
module segre_icache_ctrl #(
  parameter int unsigned WORD_SIZE         = segre_pkg::WORD_SIZE,
  parameter int unsigned ICACHE_BYTE_SIZE  = segre_pkg::ICACHE_BYTE_SIZE,
  parameter int unsigned ICACHE_INDEX_SIZE = segre_pkg::ICACHE_INDEX_SIZE,
  parameter int unsigned ICACHE_NUM_LANES  = segre_pkg::ICACHE_NUM_LANES,
  parameter int unsigned ICACHE_TAG_SIZE   = WORD_SIZE - ICACHE_INDEX_SIZE - ICACHE_BYTE_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  segre_icache_ctrl_if.slave    fetch_if,
  output logic                  data_rd_o,
  output logic                  data_wr_o,
  output logic [WORD_SIZE-1:0]  data_addr_o,
  output logic                  mmu_req_o,
  output logic [WORD_SIZE-1:0]  mmu_addr_o,
  input  logic                  mmu_gnt_i,
  input  logic                  mmu_rsp_valid_i,
  output logic [31:0]           miss_count_o
);
  import segre_pkg::*;

  localparam int unsigned TagLsb = ICACHE_INDEX_SIZE + ICACHE_BYTE_SIZE;

  icache_state_t        state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic                 pend_q, pend_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
  logic                 fetch_valid_q;

  logic                 hit;
  logic                 rd, wr, clear, ready, mmu_req;
  logic [WORD_SIZE-1:0] daddr;

  segre_icache_tag #(
    .TAG_SIZE   (ICACHE_TAG_SIZE),
    .INDEX_SIZE (ICACHE_INDEX_SIZE),
    .NUM_LANES  (ICACHE_NUM_LANES)
  ) u_tag (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .rd_index_i (fetch_if.fetch_addr[TagLsb-1:ICACHE_BYTE_SIZE]),
    .rd_tag_i   (fetch_if.fetch_addr[WORD_SIZE-1:TagLsb]),
    .hit_o      (hit),
    .wr_en_i    (wr),
    .wr_index_i (addr_q[TagLsb-1:ICACHE_BYTE_SIZE]),
    .wr_tag_i   (addr_q[WORD_SIZE-1:TagLsb]),
    .clear_i    (clear)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    miss_cnt_d = miss_cnt_q;
    rd         = 1'b0;
    wr         = 1'b0;
    clear      = 1'b0;
    ready      = 1'b0;
    mmu_req    = 1'b0;
    daddr      = addr_q;
    unique case (state_q)
      IDLE: begin
        daddr = fetch_if.fetch_addr;
        if (fetch_if.invalidate) begin
          clear = 1'b1;
        end else begin
          ready = 1'b1;
          if (fetch_if.fetch_req) begin
            if (hit) begin
              rd = 1'b1;
            end else begin
              addr_d     = fetch_if.fetch_addr;
              miss_cnt_d = miss_cnt_q + 32'd1;
              state_d    = MISS_REQ;
            end
          end
        end
      end
      MISS_REQ: begin
        mmu_req = 1'b1;
        if (fetch_if.invalidate) pend_d = 1'b1;
        if (mmu_gnt_i) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (fetch_if.invalidate) pend_d = 1'b1;
        if (mmu_rsp_valid_i) begin
          wr      = 1'b1;
          state_d = REPLAY;
        end
      end
      REPLAY: begin
        // The replay reads the just-filled line; a deferred flush lands after it.
        rd      = 1'b1;
        state_d = IDLE;
        if (pend_q || fetch_if.invalidate) begin
          clear  = 1'b1;
          pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      pend_q        <= 1'b0;
      miss_cnt_q    <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pend_q        <= pend_d;
      miss_cnt_q    <= miss_cnt_d;
      fetch_valid_q <= rd;
    end
  end

  // Outputs are forced low for the whole time reset is asserted.
  assign fetch_if.fetch_ready = rsn_i & ready;
  assign fetch_if.fetch_valid = rsn_i & fetch_valid_q;
  assign data_rd_o            = rsn_i & rd;
  assign data_wr_o            = rsn_i & wr;
  assign data_addr_o          = rsn_i ? daddr : '0;
  assign mmu_req_o            = rsn_i & mmu_req;
  assign mmu_addr_o           = (rsn_i && mmu_req) ?
                                {addr_q[WORD_SIZE-1:ICACHE_BYTE_SIZE], {ICACHE_BYTE_SIZE{1'b0}}} :
                                '0;
  assign miss_count_o         = rsn_i ? miss_cnt_q : '0;

endmodule

// File: tb/tb_segre_icache_ctrl.sv
// Directed bench for segre_icache_ctrl with hand-computed expected values.
module tb_segre_icache_ctrl;

  logic        clk = 1'b0;
  logic        rsn;
  logic        data_rd, data_wr, mmu_req;
  logic [31:0] data_addr, mmu_addr, miss_count;
  logic        mmu_gnt, mmu_rsp;
  int          checks = 0;
  int          errors = 0;

  segre_icache_ctrl_if #(.WORD_SIZE(32)) fi ();

  segre_icache_ctrl dut (
    .clk_i           (clk),
    .rsn_i           (rsn),
    .fetch_if        (fi),
    .data_rd_o       (data_rd),
    .data_wr_o       (data_wr),
    .data_addr_o     (data_addr),
    .mmu_req_o       (mmu_req),
    .mmu_addr_o      (mmu_addr),
    .mmu_gnt_i       (mmu_gnt),
    .mmu_rsp_valid_i (mmu_rsp),
    .miss_count_o    (miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full miss at minimum latency: grant in the first MISS_REQ cycle, response right after.
  task automatic miss_seq(input logic [31:0] addr, input logic [31:0] cnt);
    fi.fetch_req = 1'b1; fi.fetch_addr = addr;
    #1;
    chk("miss_ready", {31'd0, fi.fetch_ready}, 32'd1);
    chk("miss_no_rd", {31'd0, data_rd}, 32'd0);
    tick();
    fi.fetch_req = 1'b0; mmu_gnt = 1'b1;
    #1;
    chk("mmu_req", {31'd0, mmu_req}, 32'd1);
    chk("mmu_addr", mmu_addr, addr & 32'hFFFF_FFF0);
    chk("miss_count", miss_count, cnt);
    tick();
    mmu_gnt = 1'b0; mmu_rsp = 1'b1;
    #1;
    chk("refill_wr", {31'd0, data_wr}, 32'd1);
    chk("refill_addr", data_addr, addr);
    tick();
    mmu_rsp = 1'b0;
    #1;
    chk("replay_rd", {31'd0, data_rd}, 32'd1);
    tick();
    #1;
    chk("replay_valid", {31'd0, fi.fetch_valid}, 32'd1);
    chk("back_idle_ready", {31'd0, fi.fetch_ready}, 32'd1);
  endtask

  initial begin
    rsn = 1'b0; fi.fetch_req = 1'b1; fi.fetch_addr = 32'h0000_1004; fi.invalidate = 1'b0;
    mmu_gnt = 1'b0; mmu_rsp = 1'b0;
    tick(); tick();
    #1;
    chk("rst_ready", {31'd0, fi.fetch_ready}, 32'd0);
    chk("rst_rd", {31'd0, data_rd}, 32'd0);
    chk("rst_mmu_req", {31'd0, mmu_req}, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    chk("rst_valid", {31'd0, fi.fetch_valid}, 32'd0);

    // Cold miss with gnt one cycle later and rsp three cycles later
    rsn = 1'b1;
    #1;
    chk("cold_ready", {31'd0, fi.fetch_ready}, 32'd1);
    chk("cold_no_rd", {31'd0, data_rd}, 32'd0);
    tick();
    fi.fetch_req = 1'b0; mmu_gnt = 1'b1;
    #1;
    chk("cold_mmu_req", {31'd0, mmu_req}, 32'd1);
    chk("cold_mmu_addr", mmu_addr, 32'h0000_1000);
    chk("cold_busy", {31'd0, fi.fetch_ready}, 32'd0);
    tick();
    mmu_gnt = 1'b0;
    #1;
    chk("cold_req_drop", {31'd0, mmu_req}, 32'd0);
    tick(); tick();
    mmu_rsp = 1'b1;
    #1;
    chk("cold_wr", {31'd0, data_wr}, 32'd1);
    chk("cold_wr_addr", data_addr, 32'h0000_1004);
    tick();
    mmu_rsp = 1'b0;
    #1;
    chk("cold_replay_rd", {31'd0, data_rd}, 32'd1);
    chk("cold_replay_nv", {31'd0, fi.fetch_valid}, 32'd0);
    tick();
    #1;
    chk("cold_valid", {31'd0, fi.fetch_valid}, 32'd1);
    chk("cold_count", miss_count, 32'd1);

    // Hit stream over the whole line
    for (int i = 0; i < 4; i++) begin
      fi.fetch_req = 1'b1; fi.fetch_addr = 32'h0000_1000 + 32'(4 * i);
      #1;
      chk("hit_rd", {31'd0, data_rd}, 32'd1);
      chk("hit_addr", data_addr, 32'h0000_1000 + 32'(4 * i));
      if (i > 0) chk("hit_valid", {31'd0, fi.fetch_valid}, 32'd1);
      tick();
    end
    fi.fetch_req = 1'b0;
    #1;
    chk("hit_last_valid", {31'd0, fi.fetch_valid}, 32'd1);
    chk("hit_no_mmu", {31'd0, mmu_req}, 32'd0);
    chk("hit_count", miss_count, 32'd1);
    tick();
    #1;
    chk("hit_valid_end", {31'd0, fi.fetch_valid}, 32'd0);

    // Conflict on index 0
    miss_seq(32'h0000_2004, 32'd2);
    miss_seq(32'h0000_1004, 32'd3);

    // Invalidate in IDLE beats a request that would hit
    fi.fetch_req = 1'b1; fi.fetch_addr = 32'h0000_1004; fi.invalidate = 1'b1;
    #1;
    chk("inv_ready", {31'd0, fi.fetch_ready}, 32'd0);
    chk("inv_no_rd", {31'd0, data_rd}, 32'd0);
    tick();
    fi.invalidate = 1'b0;
    miss_seq(32'h0000_1004, 32'd4);

    // Invalidate while waiting for the refill
    fi.fetch_req = 1'b1; fi.fetch_addr = 32'h0000_1014;
    #1;
    chk("pend_miss_rd", {31'd0, data_rd}, 32'd0);
    tick();
    fi.fetch_req = 1'b0; mmu_gnt = 1'b1;
    #1;
    chk("pend_count", miss_count, 32'd5);
    tick();
    mmu_gnt = 1'b0; fi.invalidate = 1'b1;
    #1;
    chk("pend_busy", {31'd0, fi.fetch_ready}, 32'd0);
    chk("pend_no_wr", {31'd0, data_wr}, 32'd0);
    tick();
    fi.invalidate = 1'b0; mmu_rsp = 1'b1;
    #1;
    chk("pend_wr", {31'd0, data_wr}, 32'd1);
    tick();
    mmu_rsp = 1'b0;
    #1;
    chk("pend_replay_rd", {31'd0, data_rd}, 32'd1);
    chk("pend_replay_addr", data_addr, 32'h0000_1014);
    tick();
    #1;
    chk("pend_valid", {31'd0, fi.fetch_valid}, 32'd1);
    fi.fetch_req = 1'b1; fi.fetch_addr = 32'h0000_1014;
    #1;
    chk("post_pend_miss", {31'd0, data_rd}, 32'd0);
    tick();
    fi.fetch_req = 1'b0;
    #1;
    chk("post_pend_count", miss_count, 32'd6);

    // Grant stall: request and address must hold
    for (int i = 0; i < 10; i++) begin
      mmu_gnt = 1'b0;
      #1;
      chk("stall_req", {31'd0, mmu_req}, 32'd1);
      chk("stall_addr", mmu_addr, 32'h0000_1010);
      tick();
    end
    mmu_gnt = 1'b1; mmu_rsp = 1'b1;
    #1;
    chk("gnt_rsp_same_no_wr", {31'd0, data_wr}, 32'd0);
    tick();
    mmu_gnt = 1'b0; mmu_rsp = 1'b0;
    #1;
    chk("wait_no_wr", {31'd0, data_wr}, 32'd0);
    tick();
    mmu_rsp = 1'b1;
    #1;
    chk("stall_wr", {31'd0, data_wr}, 32'd1);
    tick();
    mmu_rsp = 1'b0;
    #1;
    chk("stall_replay_rd", {31'd0, data_rd}, 32'd1);
    tick();
    #1;
    chk("stall_valid", {31'd0, fi.fetch_valid}, 32'd1);
    mmu_rsp = 1'b1;
    #1;
    chk("spurious_no_wr", {31'd0, data_wr}, 32'd0);
    tick();
    mmu_rsp = 1'b0;
    #1;
    chk("spurious_no_valid", {31'd0, fi.fetch_valid}, 32'd0);

    // Reset in MISS_WAIT, then a late response
    fi.fetch_req = 1'b1; fi.fetch_addr = 32'h0000_1024;
    tick();
    fi.fetch_req = 1'b0; mmu_gnt = 1'b1;
    #1;
    chk("rm_count", miss_count, 32'd7);
    tick();
    mmu_gnt = 1'b0; rsn = 1'b0;
    #1;
    chk("rm_ready", {31'd0, fi.fetch_ready}, 32'd0);
    chk("rm_count_rst", miss_count, 32'd0);
    chk("rm_mmu_req", {31'd0, mmu_req}, 32'd0);
    chk("rm_addr", data_addr, 32'd0);
    tick();
    rsn = 1'b1; mmu_rsp = 1'b1;
    #1;
    chk("rm_late_no_wr", {31'd0, data_wr}, 32'd0);
    chk("rm_idle_ready", {31'd0, fi.fetch_ready}, 32'd1);
    chk("rm_count_zero", miss_count, 32'd0);
    tick();
    mmu_rsp = 1'b0; fi.fetch_req = 1'b1; fi.fetch_addr = 32'h0000_1004;
    #1;
    chk("rm_valids_cleared", {31'd0, data_rd}, 32'd0);
    chk("rm_no_valid", {31'd0, fi.fetch_valid}, 32'd0);
    tick();
    fi.fetch_req = 1'b0;
    #1;
    chk("rm_count_one", miss_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
